// File: rtl/id_stage_pkg.sv
// Shared RV32I decode definitions for the ID stage.
// Opcode/func codes, field slices, immediates and the ID->EX bundle.
package id_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] RISCV_LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC       = 7'b0010111;
  localparam logic [6:0] ALU_OP_IMM  = 7'b0010011;
  localparam logic [6:0] ALU_OP_REGS = 7'b0110011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  localparam logic [6:0] STD_OP = 7'b0000000;
  localparam logic [6:0] ALT_OP = 7'b0100000;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd;
    logic            rd_we;
    logic            illegal;
  } id_ex_t;

  function automatic logic [6:0] opcode_of(input logic [31:0] i);
    return i[6:0];
  endfunction

  function automatic logic [2:0] func3_of(input logic [31:0] i);
    return i[14:12];
  endfunction

  function automatic logic [6:0] func7_of(input logic [31:0] i);
    return i[31:25];
  endfunction

  function automatic logic [4:0] rd_of(input logic [31:0] i);
    return i[11:7];
  endfunction

  function automatic logic [4:0] rs1_of(input logic [31:0] i);
    return i[19:15];
  endfunction

  function automatic logic [4:0] rs2_of(input logic [31:0] i);
    return i[24:20];
  endfunction

  function automatic logic [XLEN-1:0] imm_u(input logic [31:0] i);
    return {i[31:12], 12'b0};
  endfunction

  function automatic logic [XLEN-1:0] imm_i(input logic [31:0] i);
    return {{20{i[31]}}, i[31:20]};
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch-side, regfile and execute-side signals of the ID stage.
// slave is the stage's view, master the surrounding pipeline's.
interface id_stage_if;
  import id_stage_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_instr;

  logic [4:0]      rf_rs1_addr;
  logic [4:0]      rf_rs2_addr;
  logic [XLEN-1:0] rf_rs1_data;
  logic [XLEN-1:0] rf_rs2_data;

  logic            out_valid;
  logic            out_ready;
  logic [6:0]      out_opcode;
  logic [2:0]      out_func3;
  logic [6:0]      out_func7;
  logic [XLEN-1:0] out_op_a;
  logic [XLEN-1:0] out_op_b;
  logic [4:0]      out_rd;
  logic            out_rd_we;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_pc, in_instr,
    input  rf_rs1_data, rf_rs2_data,
    input  out_ready,
    output in_ready, rf_rs1_addr, rf_rs2_addr,
    output out_valid, out_opcode, out_func3,
    output out_func7, out_op_a, out_op_b,
    output out_rd, out_rd_we, out_illegal
  );

  modport master (
    output in_valid, in_pc, in_instr,
    output rf_rs1_data, rf_rs2_data,
    output out_ready,
    input  in_ready, rf_rs1_addr, rf_rs2_addr,
    input  out_valid, out_opcode, out_func3,
    input  out_func7, out_op_a, out_op_b,
    input  out_rd, out_rd_we, out_illegal
  );

endinterface

// File: rtl/id_decode.sv
// Combinational RV32I decode for the ALU subset.
// LUI is folded into AUIPC with a zero base operand.
module id_decode
  import id_stage_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output id_ex_t          dec_o
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       shift;
  logic       legal;

  always_comb begin
    opc   = opcode_of(instr_i);
    f3    = func3_of(instr_i);
    f7    = func7_of(instr_i);
    shift = (f3 == F3_SLL) || (f3 == F3_SR);
    legal = 1'b0;

    dec_o        = '0;
    dec_o.opcode = opc;
    dec_o.func3  = f3;
    dec_o.func7  = f7;
    dec_o.rd     = rd_of(instr_i);

    unique case (1'b1)
      (opc == RISCV_LUI): begin
        legal        = 1'b1;
        dec_o.opcode = AUIPC;
        dec_o.func3  = '0;
        dec_o.func7  = '0;
        dec_o.op_b   = imm_u(instr_i);
      end
      (opc == AUIPC): begin
        legal       = 1'b1;
        dec_o.func3 = '0;
        dec_o.func7 = '0;
        dec_o.op_a  = pc_i;
        dec_o.op_b  = imm_u(instr_i);
      end
      (opc == ALU_OP_IMM) && shift: begin
        legal = (f7 == STD_OP) ||
                ((f7 == ALT_OP) && (f3 == F3_SR));
        dec_o.op_a = rs1_data_i;
        dec_o.op_b = {27'b0, instr_i[24:20]};
      end
      (opc == ALU_OP_IMM) && !shift: begin
        legal       = 1'b1;
        dec_o.func7 = '0;
        dec_o.op_a  = rs1_data_i;
        dec_o.op_b  = imm_i(instr_i);
      end
      (opc == ALU_OP_REGS): begin
        legal = (f7 == STD_OP) ||
                ((f7 == ALT_OP) &&
                 ((f3 == F3_ADD) || (f3 == F3_SR)));
        dec_o.op_a = rs1_data_i;
        dec_o.op_b = rs2_data_i;
      end
      default: legal = 1'b0;
    endcase

    // Malformed words reach EX raw, with no operands and no writeback.
    if (!legal) begin
      dec_o.opcode = opc;
      dec_o.func3  = f3;
      dec_o.func7  = f7;
      dec_o.op_a   = '0;
      dec_o.op_b   = '0;
    end
    dec_o.illegal = !legal;
    dec_o.rd_we   = legal && (dec_o.rd != 5'd0);
  end

endmodule

// File: rtl/id_stage.sv
// ID stage: regfile read, decode and a 2-entry skid buffer.
// in_ready and every out_* signal come straight from flops.
module id_stage
  import id_stage_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  id_stage_if.slave  bus
);

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] ONE   = 2'b01;
  localparam logic [1:0] TWO   = 2'b11;

  logic [1:0] state_q, state_d;
  id_ex_t     main_q, main_d;
  id_ex_t     skid_q, skid_d;
  logic       in_ready_q, in_ready_d;
  id_ex_t     dec;
  logic       accept;
  logic       drain;

  assign bus.rf_rs1_addr = rs1_of(bus.in_instr);
  assign bus.rf_rs2_addr = rs2_of(bus.in_instr);

  id_decode u_decode (
    .pc_i       (bus.in_pc),
    .instr_i    (bus.in_instr),
    .rs1_data_i (bus.rf_rs1_data),
    .rs2_data_i (bus.rf_rs2_data),
    .dec_o      (dec)
  );

  assign accept = bus.in_valid && in_ready_q;
  assign drain  = state_q[0] && bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = dec;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_d = dec;
          end else if (accept) begin
            state_d = TWO;
            skid_d  = dec;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = state_q[0];
  assign bus.out_opcode  = main_q.opcode;
  assign bus.out_func3   = main_q.func3;
  assign bus.out_func7   = main_q.func7;
  assign bus.out_op_a    = main_q.op_a;
  assign bus.out_op_b    = main_q.op_b;
  assign bus.out_rd      = main_q.rd;
  assign bus.out_rd_we   = main_q.rd_we;
  assign bus.out_illegal = main_q.illegal;

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode/issue stage feeding the combinational ALU of the RV32I core.
- Accepts fetched {pc, instr} beats through a valid/ready handshake and reads the register file.
- Produces the ALU control fields (opcode, func3, func7) and operands (op_a, op_b), plus the writeback tag.
- Output is registered through a 2-entry skid buffer, so in_ready and all outputs are flop-driven.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous pipeline flush (branch redirect)
- in_valid  in  1  fetch beat valid
- in_ready  out  1  stage can accept a beat (registered)
- in_pc  in  32  pc of instruction
- in_instr  in  32  raw instruction word
- rf_rs1_addr  out  5  regfile read address 1 = in_instr[19:15] (combinational)
- rf_rs2_addr  out  5  regfile read address 2 = in_instr[24:20] (combinational)
- rf_rs1_data  in  32  regfile read data 1, same cycle
- rf_rs2_data  in  32  regfile read data 2, same cycle
- out_valid  out  1  decoded beat valid
- out_ready  in  1  execute stage accepts
- out_opcode  out  7  ALU opcode
- out_func3  out  3  ALU func3
- out_func7  out  7  ALU func7
- out_op_a  out  32  ALU rs1 operand
- out_op_b  out  32  ALU rs2 operand
- out_rd  out  5  destination register
- out_rd_we  out  1  writeback enable
- out_illegal  out  1  unsupported or malformed instruction

Behaviour:
- Reset values: out_valid=0, in_ready=1, all data outputs 0, both buffer entries empty.
- Handshakes:
  - Input transfer when in_valid&&in_ready at a clk edge; output transfer when out_valid&&out_ready.
  - Latency 1: a beat accepted at edge N is presented at out_* after edge N, if the buffer was empty or drains at N.
- Buffer:
  - Main register plus one skid register; occupancy states EMPTY, ONE, TWO.
  - EMPTY→ONE on accept. ONE→EMPTY on drain without accept. ONE→ONE on accept+drain. ONE→TWO on accept without drain. TWO→ONE on drain, with skid moving to main.
  - in_ready is registered low exactly when the next state is TWO.
  - A beat is never dropped or duplicated, and order is preserved.
  - Outputs hold stable while out_valid&&!out_ready.
- Regfile data is captured together with its instruction at accept time; the stage performs no hazard checking.
- Decode (opcode = instr[6:0], func3 = instr[14:12], rd = instr[11:7]):
  - LUI 0110111: out_opcode=AUIPC (0010111), op_a=0, op_b={instr[31:12],12'b0}.
  - AUIPC: op_a=pc, op_b={instr[31:12],12'b0}, func3=0, func7=0.
  - OP_IMM 0010011: op_a=rs1_data, op_b=sign-extended instr[31:20], func7=0.
  - OP_IMM shifts (func3 001/101): op_b={27'b0,instr[24:20]}, func7=instr[31:25].
    - Legal func7: 0000000, or 0100000 only with func3 101.
  - OP 0110011: op_a=rs1_data, op_b=rs2_data, func7=instr[31:25].
    - Legal func7: 0000000, or 0100000 only with func3 000/101.
- Illegal cases: any other opcode or illegal func7.
  - out_illegal=1, rd_we=0, op_a=op_b=0.
  - opcode, func3 and func7 pass through raw.
- out_rd_we=1 only for a legal instruction with rd≠0.
- Flush:
  - Empties both entries at the edge; out_valid=0 and in_ready=1 afterwards.
  - An input beat presented in the flush cycle is discarded.
  - An output transfer in the flush cycle still counts as taken.
- Reset mid-operation: immediate return to reset values, regardless of clk.

Decomposition:
- Shared arch defines gain RISCV_LUI, plus opcode field slices and U/I immediate helpers.
- Existing defines are reused: AUIPC, ALU_OP_IMM, ALU_OP_REGS, func3 codes, STD_OP/ALT_OP.
- One combinational sub-module, id_decode: instr/pc/rs data in, decoded bundle out.
- id_stage holds only the skid buffer and the handshakes.

Test Plan:
- ADDI x5,x0,-1 (0xFFF00293), out_ready=1 → next cycle opcode 0x13, func3 0, op_b 0xFFFFFFFF, rd 5, rd_we 1, illegal 0.
- SUB x3,x1,x2 (0x402081B3), rs1_data 10, rs2_data 3 → func3 0, func7 0x20, op_a 10, op_b 3, rd_we 1.
- LUI x1,0x12345 (0x123450B7) → opcode 0x17, op_a 0, op_b 0x12345000; SRAI x2,x2,4 (0x40415113) → op_b 4, func7 0x20.
- Backpressure: out_ready=0, three back-to-back beats → two accepted, in_ready=0 after the second edge; then out_ready=1 → beats emerge in order, in_ready returns 1.
- Illegal cases: 0x0000007F → illegal 1, rd_we 0. SLLI with func7 0x20 (0x40009093) → illegal 1. ADD with rd=x0 → rd_we 0, illegal 0.
- Flush with two entries held plus an in_valid beat → next cycle out_valid 0, in_ready 1, flushed beat never appears. Async reset asserted mid-stream → outputs at reset values without a clk edge.
